seg_shift_serializer: RTL and testbench



---
 rtl/seg_shift_serializer_if.sv | 11 +
 rtl/seg_shift_serializer.sv | 131 +++++++++++++
 tb/tb_seg_shift_serializer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_shift_serializer_if.sv
// Parallel frame handshake between the segment driver and the shift serializer.
interface seg_shift_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] p_in;
    logic             p_valid;
    logic             p_ready;

    modport master (output p_in, output p_valid, input p_ready);
    modport slave  (input p_in, input p_valid, output p_ready);
endinterface

// File: rtl/seg_shift_serializer.sv
// Shifts one display frame out to a 74HC595-style chain, then pulses the storage latch.
// Define SEG_SHIFT_SERIALIZER_LSB_FIRST_EN to send bit 0 first instead of bit WIDTH-1.
module seg_shift_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_shift_serializer_if.slave p_if,
    output logic                  s_clk,
    output logic                  s_out,
    output logic                  latch,
    output logic                  busy
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             s_clk_q, s_clk_d;
    logic             s_out_q, s_out_d;
    logic             latch_q, latch_d;

    logic             accept;
    logic             div_done;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_next;
    logic             first_bit;
    logic             next_bit;

`ifdef SEG_SHIFT_SERIALIZER_LSB_FIRST_EN
    assign shreg_next = shreg_q >> 1;
    assign first_bit  = p_if.p_in[0];
    assign next_bit   = shreg_q[1];
`else
    assign shreg_next = shreg_q << 1;
    assign first_bit  = p_if.p_in[WIDTH-1];
    assign next_bit   = shreg_q[WIDTH-2];
`endif

    assign accept   = p_if.p_valid && p_if.p_ready;
    assign div_done = (div_cnt_q == DivLast);
    assign last_bit = (bit_cnt_q == CntW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            s_clk_q   <= 1'b0;
            s_out_q   <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            s_clk_q   <= s_clk_d;
            s_out_q   <= s_out_d;
            latch_q   <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StShiftLo;
            StShiftLo: if (div_done) state_d = StShiftHi;
            StShiftHi: if (div_done) state_d = last_bit ? StLatch : StShiftLo;
            StLatch:   if (div_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state; div_cnt paces every half-period and the latch hold.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = '0;
        s_clk_d   = s_clk_q;
        s_out_d   = s_out_q;
        latch_d   = latch_q;
        if (state_q != StIdle && !div_done) begin
            div_cnt_d = div_cnt_q + DivW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d   = p_if.p_in;
                    s_out_d   = first_bit;
                    bit_cnt_d = CntW'(WIDTH);
                end
            end
            StShiftLo: begin
                if (div_done) s_clk_d = 1'b1;
            end
            StShiftHi: begin
                if (div_done) begin
                    s_clk_d   = 1'b0;
                    shreg_d   = shreg_next;
                    bit_cnt_d = bit_cnt_q - CntW'(1);
                    if (last_bit) begin
                        s_out_d = 1'b0;
                        latch_d = 1'b1;
                    end else begin
                        s_out_d = next_bit;
                    end
                end
            end
            StLatch: begin
                if (div_done) latch_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        p_if.p_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
    end

    assign s_clk = s_clk_q;
    assign s_out = s_out_q;
    assign latch = latch_q;
endmodule

// File: tb/tb_seg_shift_serializer.sv
// Scoreboard bench for seg_shift_serializer: expected frames queued at issue, checked at latch.
module tb_seg_shift_serializer;
    localparam int unsigned W = 16;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_clk, s_out, latch, busy;

    seg_shift_serializer_if #(.WIDTH(W)) p_if ();

    seg_shift_serializer #(.WIDTH(W), .DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p_if  (p_if),
        .s_clk (s_clk),
        .s_out (s_out),
        .latch (latch),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int frames_done = 0;
    int rises = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ex(input logic [W-1:0] msb, input logic [W-1:0] lsb);
`ifdef SEG_SHIFT_SERIALIZER_LSB_FIRST_EN
        return lsb;
`else
        return msb;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples mid-cycle; cyc is the number of the last rising edge.
    initial begin
        bit           active = 1'b0;
        bit           rise_bad = 1'b0;
        bit           prev_sclk = 1'b0;
        bit           prev_latch = 1'b0;
        int           acc = 0;
        logic [W-1:0] word = '0;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                prev_sclk = 1'b0;
                prev_latch = 1'b0;
            end else begin
                if (s_clk && !prev_sclk) begin
                    if (active) begin
                        rises++;
                        word = {word[W-2:0], s_out};
                        if (cyc != acc + (2 * rises - 1) * D) rise_bad = 1'b1;
                    end else begin
                        chk("stray_sclk_rise", 1, 0);
                    end
                end
                if (latch && !prev_latch) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_latch", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_bits", word, e);
                        chk("rise_count", rises, W);
                        chk("rise_timing", rise_bad, 0);
                        chk("latch_rise_cycle", cyc, acc + 2 * D * W);
                    end
                end
                if (!latch && prev_latch) begin
                    chk("latch_fall_cycle", cyc, acc + 2 * D * W + D);
                    chk("p_ready_return", p_if.p_ready, 1);
                    active = 1'b0;
                    frames_done++;
                end
                if (p_if.p_valid && p_if.p_ready) begin
                    active = 1'b1;
                    acc = cyc + 1;
                    rises = 0;
                    word = '0;
                    rise_bad = 1'b0;
                end
                prev_sclk = s_clk;
                prev_latch = latch;
            end
        end
    end

    // Returns the cycle in which the handshake was presented; accept edge is hs+1.
    task automatic send(input logic [W-1:0] d, input bit hold, output int hs);
        int n = 0;
        p_if.p_in = d;
        p_if.p_valid = 1'b1;
        hs = -1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (p_if.p_ready && rst_n) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (!hold) p_if.p_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (frames_done < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_in_time", frames_done >= target, 1);
    endtask

    initial begin
        int hs1, hs2, n;
        p_if.p_in = '0;
        p_if.p_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {p_if.p_ready, busy, s_clk, s_out, latch}, 5'b10000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {p_if.p_ready, busy, s_clk, s_out, latch}, 5'b10000);
        end

        @(posedge clk); #1;
        exp_q.push_back(ex(16'hFE40, 16'h027F));
        send(16'hFE40, 1'b0, hs1);
        wait_done(1);

        @(posedge clk); #1;
        exp_q.push_back(ex(16'hA55A, 16'h5AA5));
        exp_q.push_back(ex(16'h0F0F, 16'hF0F0));
        send(16'hA55A, 1'b1, hs1);
        send(16'h0F0F, 1'b0, hs2);
        chk("b2b_accept_gap", hs2 - (hs1 + 1), 2 * D * W + D);
        wait_done(3);

        // Upstream noise while shifting must not disturb the frame in flight.
        @(posedge clk); #1;
        exp_q.push_back(ex(16'h3C81, 16'h813C));
        send(16'h3C81, 1'b0, hs1);
        for (int i = 0; i < 12; i++) begin
            p_if.p_in = W'($urandom);
            p_if.p_valid = i[0];
            @(negedge clk);
            chk("ready_low_in_shift", {p_if.p_ready, busy}, 2'b01);
            @(posedge clk); #1;
        end
        p_if.p_valid = 1'b0;
        wait_done(4);

        @(posedge clk); #1;
        exp_q.push_back(ex(16'h0001, 16'h8000));
        send(16'h0001, 1'b0, hs1);
        wait_done(5);

        // Abort a frame after its 7th shift clock; nothing is queued for it.
        @(posedge clk); #1;
        send(16'h1234, 1'b0, hs1);
        n = 0;
        while (rises < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("seventh_rise_seen", rises, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {p_if.p_ready, busy, s_clk, s_out, latch}, 5'b10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk); #1;
        exp_q.push_back(ex(16'h5AC3, 16'hC35A));
        send(16'h5AC3, 1'b0, hs1);
        wait_done(6);
        repeat (10) @(negedge clk);
        chk("latch_pulses_total", frames_done, 6);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
